// File: rtl/spi_pkg.sv
// ============================================================================
//  Module     : spi_pkg
//  Description: Shared constants for the SPI serial-clock engine: FSM state
//               encodings and clock-phase mode values.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_TAIL   = 2'd2;

    // Clock-phase modes
    localparam logic c_CPHA_LEAD_SAMPLE = 1'b0;  // sample leading, shift trailing
    localparam logic c_CPHA_LEAD_SHIFT  = 1'b1;  // shift leading, sample trailing

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen_if.sv
// ============================================================================
//  Module     : spi_sclk_gen_if
//  Description: Control/strobe bundle between the SPI master FSM / data path
//               and the serial-clock engine.
//               master : drives start/div/cpol/cpha/nbits, observes strobes
//               slave  : the clock engine itself
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_sclk_gen_if #(
    parameter int DIV_W   = 8,
    parameter int FRAME_W = 5
);
    logic               i_start;
    logic [DIV_W-1:0]   i_div;
    logic               i_cpol;
    logic               i_cpha;
    logic [FRAME_W-1:0] i_nbits;

    logic               o_sclk;
    logic               o_busy;
    logic               o_done;
    logic               o_leading_edge;
    logic               o_trailing_edge;
    logic               o_sample;
    logic               o_shift;
    logic [FRAME_W-1:0] o_bit_count;

    modport master (
        output i_start, i_div, i_cpol, i_cpha, i_nbits,
        input  o_sclk, o_busy, o_done, o_leading_edge, o_trailing_edge,
               o_sample, o_shift, o_bit_count
    );

    modport slave (
        input  i_start, i_div, i_cpol, i_cpha, i_nbits,
        output o_sclk, o_busy, o_done, o_leading_edge, o_trailing_edge,
               o_sample, o_shift, o_bit_count
    );
endinterface

`default_nettype wire

// File: rtl/spi_half_period_cnt.sv
// ============================================================================
//  Module     : spi_half_period_cnt
//  Description: Reloadable down-counter that times one SCLK half-period.
//               i_clk   - system clock
//               i_rst   - synchronous reset, active-low
//               i_load  - load i_value (has priority over counting)
//               i_value - reload value (half-period minus 1)
//               o_tick  - high while the count is zero
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_half_period_cnt #(
    parameter int DIV_W = 8
) (
    input  wire             i_clk,
    input  wire             i_rst,
    input  wire             i_load,
    input  wire [DIV_W-1:0] i_value,
    output logic            o_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
//  Module     : spi_sclk_gen
//  Description: SPI serial-clock and bit-timing engine. Generates SCLK with a
//               runtime half-period, all CPOL/CPHA modes, runtime frame length,
//               and registered edge/sample/shift strobes plus start/busy/done.
//               i_clk - system clock
//               i_rst - synchronous reset, active-low
//               bus   - control inputs and strobe outputs (slave modport)
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int FRAME_W = 5
) (
    input  wire           i_clk,
    input  wire           i_rst,
    spi_sclk_gen_if.slave bus
);

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_div;
    logic               r_cpol;
    logic               r_cpha;
    logic [FRAME_W-1:0] r_nbits;
    logic [FRAME_W:0]   r_edge_cnt;   // edges already emitted in this frame
    logic               r_sclk;
    logic               r_busy;
    logic               r_done;
    logic               r_lead;
    logic               r_trail;
    logic               r_sample;
    logic               r_shift;
    logic [FRAME_W-1:0] r_bit_count;

    logic               w_idle;
    logic               w_accept;
    logic               w_tick;
    logic               w_load;
    logic [DIV_W-1:0]   w_value;
    logic               w_leading;
    logic               w_last;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_accept = w_idle && bus.i_start;
    // Reload on frame start and on every ACTIVE edge; the reload at the last
    // edge times the TAIL half-period.
    assign w_load   = w_accept || ((r_state == c_ST_ACTIVE) && w_tick);
    assign w_value  = w_idle ? bus.i_div : r_div;

    // Even edge index = leading edge; the final edge is index 2*nbits+1.
    assign w_leading = ~r_edge_cnt[0];
    assign w_last    = (r_edge_cnt == {r_nbits, 1'b1});

    spi_half_period_cnt #(
        .DIV_W (DIV_W)
    ) u_half_period_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_value (w_value),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= c_ST_IDLE;
            r_div       <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_nbits     <= '0;
            r_edge_cnt  <= '0;
            r_sclk      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lead      <= 1'b0;
            r_trail     <= 1'b0;
            r_sample    <= 1'b0;
            r_shift     <= 1'b0;
            r_bit_count <= '0;
        end else begin
            r_done   <= 1'b0;
            r_lead   <= 1'b0;
            r_trail  <= 1'b0;
            r_sample <= 1'b0;
            r_shift  <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    // CPOL tracks the input while idle so SCLK rests at the
                    // requested level before the frame begins.
                    r_cpol      <= bus.i_cpol;
                    r_sclk      <= bus.i_cpol;
                    r_edge_cnt  <= '0;
                    r_bit_count <= '0;
                    if (bus.i_start) begin
                        r_div   <= bus.i_div;
                        r_cpha  <= bus.i_cpha;
                        r_nbits <= bus.i_nbits;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_ACTIVE;
                    end
                end

                c_ST_ACTIVE: begin
                    // Bit index advances the cycle after a non-final trailing
                    // edge; the last trailing edge leaves it at nbits.
                    if (r_trail && (r_bit_count != r_nbits)) begin
                        r_bit_count <= r_bit_count + FRAME_W'(1);
                    end
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + (FRAME_W+1)'(1);
                        if (w_leading) begin
                            r_lead <= 1'b1;
                            if (r_cpha == c_CPHA_LEAD_SAMPLE) begin
                                r_sample <= 1'b1;
                            end else begin
                                r_shift <= 1'b1;
                            end
                        end else begin
                            r_trail <= 1'b1;
                            if (r_cpha == c_CPHA_LEAD_SHIFT) begin
                                r_sample <= 1'b1;
                            end else if (!w_last) begin
                                r_shift <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= c_ST_TAIL;
                        end
                    end
                end

                c_ST_TAIL: begin
                    // CS hold: one idle-level half-period before done.
                    if (w_tick) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_bit_count <= '0;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_sclk          = r_sclk;
    assign bus.o_busy          = r_busy;
    assign bus.o_done          = r_done;
    assign bus.o_leading_edge  = r_lead;
    assign bus.o_trailing_edge = r_trail;
    assign bus.o_sample        = r_sample;
    assign bus.o_shift         = r_shift;
    assign bus.o_bit_count     = r_bit_count;

endmodule

`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
// ============================================================================
//  Module     : tb_spi_sclk_gen
//  Description: Self-checking bench for spi_sclk_gen. A frame-timing model
//               derives every output from the cycle offset since start, and
//               directed frames pin that model with literal expectations.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sclk_gen;

    localparam int DIV_W   = 8;
    localparam int FRAME_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_sclk_gen_if #(.DIV_W(DIV_W), .FRAME_W(FRAME_W)) bus ();

    spi_sclk_gen #(
        .DIV_W   (DIV_W),
        .FRAME_W (FRAME_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-timing model. With H = div+1 and N = nbits+1, relative to the
    // start cycle t: edge j (0-based) lands at t+1+(j+1)*H, the last edge is
    // j = 2N-1 and done lands at t+1+(2N+1)*H.
    // ------------------------------------------------------------------
    bit m_active, m_rst, m_done_now, m_cpol_q, m_cpha;
    int m_k, m_H, m_N;
    int mm, mm2, mj;
    bit e_sclk, e_busy, e_done, e_lead, e_trail, e_sample, e_shift;
    int e_bc;

    always @(posedge clk) begin
        cyc++;
        m_done_now = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_cpol_q = 1'b0;
            m_rst    = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == 1 + (2*m_N + 1)*m_H) begin
                    m_active   = 1'b0;
                    m_done_now = 1'b1;
                end
            end else begin
                m_cpol_q = bus.i_cpol;
                if (bus.i_start) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_H      = int'(bus.i_div) + 1;
                    m_N      = int'(bus.i_nbits) + 1;
                    m_cpha   = bus.i_cpha;
                end
            end
        end

        e_sclk = m_rst ? 1'b0 : m_cpol_q;
        e_busy = 0; e_lead = 0; e_trail = 0; e_sample = 0; e_shift = 0; e_bc = 0;
        e_done = m_done_now;
        if (m_active) begin
            e_busy = 1'b1;
            mm = (m_k - 1) / m_H;
            if (mm > 2*m_N) mm = 2*m_N;
            if (((m_k - 1) % m_H == 0) && mm >= 1) begin
                mj      = mm - 1;
                e_lead  = (mj % 2 == 0);
                e_trail = (mj % 2 == 1);
                e_sample = m_cpha ? e_trail : e_lead;
                e_shift  = m_cpha ? e_lead  : (e_trail && (mj != 2*m_N - 1));
            end
            e_sclk = m_cpol_q ^ mm[0];
            if (m_k >= 2) begin
                mm2 = (m_k - 2) / m_H;
                if (mm2 > 2*m_N) mm2 = 2*m_N;
                e_bc = mm2 / 2;
                if (e_bc > m_N - 1) e_bc = m_N - 1;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("sclk",     bus.o_sclk,          e_sclk);
            check("busy",     bus.o_busy,          e_busy);
            check("done",     bus.o_done,          e_done);
            check("leading",  bus.o_leading_edge,  e_lead);
            check("trailing", bus.o_trailing_edge, e_trail);
            check("sample",   bus.o_sample,        e_sample);
            check("shift",    bus.o_shift,         e_shift);
            check("bit_count", bus.o_bit_count,    e_bc);
        end
    end

    // ------------------------------------------------------------------
    // Directed-frame measurements taken from DUT outputs
    // ------------------------------------------------------------------
    int t0, n_edges, n_samp, n_shift, n_done, first_edge, last_edge;
    int done_cyc, max_bc, min_gap, max_gap, prev_edge;

    task automatic clear_meas();
        n_edges = 0; n_samp = 0; n_shift = 0; n_done = 0;
        first_edge = -1; last_edge = -1; done_cyc = -1; max_bc = 0;
        min_gap = 1000000; max_gap = 0; prev_edge = -1;
    endtask

    task automatic meas();
        if (bus.o_leading_edge || bus.o_trailing_edge) begin
            n_edges++;
            if (first_edge < 0) first_edge = cyc - t0;
            if (prev_edge >= 0) begin
                if (cyc - prev_edge < min_gap) min_gap = cyc - prev_edge;
                if (cyc - prev_edge > max_gap) max_gap = cyc - prev_edge;
            end
            prev_edge = cyc;
            last_edge = cyc;
        end
        if (bus.o_sample) n_samp++;
        if (bus.o_shift)  n_shift++;
        if (bus.o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (int'(bus.o_bit_count) > max_bc) max_bc = int'(bus.o_bit_count);
    endtask

    // Call right after a negedge: request a frame in the current cycle.
    task automatic set_frame(input int div, input bit cpol, input bit cpha, input int nbits);
        bus.i_div   = DIV_W'(div);
        bus.i_cpol  = cpol;
        bus.i_cpha  = cpha;
        bus.i_nbits = FRAME_W'(nbits);
        bus.i_start = 1'b1;
        t0 = cyc;
        clear_meas();
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            meas();
        end
        check("done_within_budget", n_done, 1);
    endtask

    int d1;

    initial begin
        bus.i_start = 1'b0;
        bus.i_div   = '0;
        bus.i_cpol  = 1'b0;
        bus.i_cpha  = 1'b0;
        bus.i_nbits = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.o_busy, 0);
        check("reset_sclk", bus.o_sclk, 0);
        check("reset_bit_count", bus.o_bit_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: div=1, mode 0, 8 bits
        set_frame(1, 1'b0, 1'b0, 7);
        run_until_done(100);
        check("t1_first_edge", first_edge, 3);
        check("t1_edges", n_edges, 16);
        check("t1_samples", n_samp, 8);
        check("t1_shifts", n_shift, 7);
        check("t1_max_bit_count", max_bc, 7);
        check("t1_gap_min", min_gap, 2);
        check("t1_gap_max", max_gap, 2);
        check("t1_done_after_last", done_cyc - last_edge, 2);
        check("t1_done_offset", done_cyc - t0, 35);

        // 2: div=0, mode 3, 4 bits
        @(negedge clk);
        set_frame(0, 1'b1, 1'b1, 3);
        run_until_done(50);
        check("t2_first_edge", first_edge, 2);
        check("t2_edges", n_edges, 8);
        check("t2_shifts", n_shift, 4);
        check("t2_samples", n_samp, 4);
        check("t2_gap", max_gap, 1);
        check("t2_done_after_last", done_cyc - last_edge, 1);
        @(negedge clk);
        check("t2_idle_sclk", bus.o_sclk, 1);

        // 3: start held high across two frames
        @(negedge clk);
        set_frame(2, 1'b0, 1'b0, 1);
        d1 = -1;
        for (int i = 0; i < 80 && n_done < 2; i++) begin
            @(negedge clk);
            if (d1 >= 0 && cyc > d1) bus.i_start = 1'b0;
            meas();
            if (n_done == 1 && d1 < 0) d1 = cyc;
            if (d1 >= 0 && cyc == d1 + 1) check("t3_busy_after_done", bus.o_busy, 1);
        end
        bus.i_start = 1'b0;
        check("t3_dones", n_done, 2);
        check("t3_first_frame", d1 - t0, 16);
        check("t3_second_frame", done_cyc - d1, 16);
        check("t3_edges", n_edges, 8);

        // 4: mid-frame start pulse and div change are ignored
        @(negedge clk);
        set_frame(3, 1'b0, 1'b0, 3);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus.i_start = (i == 10);
            if (i == 10) bus.i_div = DIV_W'(9);
            meas();
        end
        check("t4_dones", n_done, 1);
        check("t4_done_offset", done_cyc - t0, 37);
        check("t4_gap_min", min_gap, 4);
        check("t4_gap_max", max_gap, 4);

        // 5: reset in the cycle of edge 5
        @(negedge clk);
        set_frame(2, 1'b1, 1'b0, 7);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            meas();
        end
        check("t5_edges_before_reset", n_edges, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy_after_reset", bus.o_busy, 0);
        check("t5_sclk_after_reset", bus.o_sclk, 0);
        check("t5_lead_after_reset", bus.o_leading_edge, 0);
        rst_n = 1'b1;
        clear_meas();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            meas();
            if (bus.o_busy) n_edges++;
        end
        check("t5_no_done", n_done, 0);
        check("t5_stays_idle", n_edges, 0);
        check("t5_idle_sclk", bus.o_sclk, 1);

        // 6: maximum divisor, single-bit frame
        @(negedge clk);
        set_frame(255, 1'b0, 1'b0, 0);
        run_until_done(1000);
        check("t6_edges", n_edges, 2);
        check("t6_first_edge", first_edge, 257);
        check("t6_gap", last_edge - t0 - first_edge, 256);
        check("t6_samples", n_samp, 1);
        check("t6_shifts", n_shift, 0);
        check("t6_done_after_last", done_cyc - last_edge, 256);

        // Randomized traffic, including mid-frame noise and occasional resets
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            bus.i_start = ($urandom_range(0, 9) == 0);
            bus.i_div   = ($urandom_range(0, 15) == 0) ? DIV_W'($urandom_range(0, 40))
                                                      : DIV_W'($urandom_range(0, 5));
            bus.i_cpol  = 1'($urandom_range(0, 1));
            bus.i_cpha  = 1'($urandom_range(0, 1));
            bus.i_nbits = FRAME_W'($urandom_range(0, 31));
            rst_n       = ($urandom_range(0, 2999) != 0);
        end

        @(negedge clk);
        rst_n       = 1'b1;
        bus.i_start = 1'b0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
